// File: rtl/ibuf_ctrl_pkg.sv
// Shared types for the input-buffer layer sequencer: FSM state encoding and default widths.
package ibuf_ctrl_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned CW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    LOAD = 3'd2,
    WGT  = 3'd3,
    COMP = 3'd4,
    DONE = 3'd5
  } state_e;

endpackage

// File: rtl/ibuf_layer_ctrl.sv
// Layer sequencer: per channel, program plane address, then load block / fetch weights / run PE until mapend.
// start->init_addr_en 1 cycle, blkend->pe_start 2 cycles, result_valid->data_load 1 cycle; WGT stalls while a fetch is pending.
module ibuf_layer_ctrl
  import ibuf_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] cfg_base_addr,
  input  logic [AW-1:0] cfg_ch_stride,
  input  logic [CW-1:0] cfg_num_ch,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] init_addr,
  output logic          init_addr_en,
  output logic          data_load,
  input  logic          blkend,
  input  logic          mapend,
  input  logic          weight_load,
  output logic          wgt_req,
  input  logic          wgt_ready,
  output logic          pe_start,
  input  logic          result_valid,
  output logic [CW-1:0] ch_cnt,
  output logic [CW-1:0] blk_cnt
);

  state_e        state_q, state_d;
  logic [AW-1:0] ch_addr_q, ch_addr_d;
  logic [AW-1:0] stride_q, stride_d;
  logic [CW-1:0] num_ch_q, num_ch_d;
  logic [CW-1:0] ch_cnt_q, ch_cnt_d;
  logic [CW-1:0] blk_cnt_q, blk_cnt_d;
  logic          map_last_q, map_last_d;
  logic          wgt_pend_q, wgt_pend_d;
  logic          data_load_q, data_load_d;
  logic          pe_start_q, pe_start_d;

  always_comb begin
    state_d    = state_q;
    ch_addr_d  = ch_addr_q;
    stride_d   = stride_q;
    num_ch_d   = num_ch_q;
    ch_cnt_d   = ch_cnt_q;
    blk_cnt_d  = blk_cnt_q;
    map_last_d = map_last_q;
    wgt_pend_d = wgt_pend_q;

    // A fresh weight request beats a same-cycle delivery so it is not lost.
    if (state_q != IDLE && weight_load) begin
      wgt_pend_d = 1'b1;
    end else if (wgt_ready) begin
      wgt_pend_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          stride_d  = cfg_ch_stride;
          num_ch_d  = cfg_num_ch;
          ch_addr_d = cfg_base_addr;
          ch_cnt_d  = '0;
          state_d   = (cfg_num_ch == '0) ? DONE : INIT;
        end
      end
      INIT: begin
        blk_cnt_d  = '0;
        map_last_d = 1'b0;
        state_d    = LOAD;
      end
      LOAD: begin
        if (blkend) begin
          map_last_d = mapend;
          blk_cnt_d  = blk_cnt_q + CW'(1);
          state_d    = WGT;
        end
      end
      WGT: begin
        if (!wgt_pend_q || (wgt_ready && !weight_load)) begin
          state_d = COMP;
        end
      end
      COMP: begin
        if (result_valid) begin
          if (!map_last_q) begin
            state_d = LOAD;
          end else if (ch_cnt_q + CW'(1) == num_ch_q) begin
            state_d = DONE;
          end else begin
            ch_cnt_d  = ch_cnt_q + CW'(1);
            ch_addr_d = ch_addr_q + stride_q;
            state_d   = INIT;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      ch_addr_d  = '0;
      stride_d   = '0;
      num_ch_d   = '0;
      ch_cnt_d   = '0;
      blk_cnt_d  = '0;
      map_last_d = 1'b0;
      wgt_pend_d = 1'b0;
    end

    data_load_d = (state_d == LOAD);
    pe_start_d  = (state_d == COMP) && (state_q != COMP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_addr_q   <= '0;
      stride_q    <= '0;
      num_ch_q    <= '0;
      ch_cnt_q    <= '0;
      blk_cnt_q   <= '0;
      map_last_q  <= 1'b0;
      wgt_pend_q  <= 1'b0;
      data_load_q <= 1'b0;
      pe_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_addr_q   <= ch_addr_d;
      stride_q    <= stride_d;
      num_ch_q    <= num_ch_d;
      ch_cnt_q    <= ch_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      map_last_q  <= map_last_d;
      wgt_pend_q  <= wgt_pend_d;
      data_load_q <= data_load_d;
      pe_start_q  <= pe_start_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign init_addr_en = (state_q == INIT);
  assign init_addr    = (state_q == INIT) ? ch_addr_q : '0;
  assign data_load    = data_load_q;
  assign wgt_req      = (state_q == WGT) && wgt_pend_q;
  assign pe_start     = pe_start_q;
  assign ch_cnt       = ch_cnt_q;
  assign blk_cnt      = blk_cnt_q;

endmodule

// File: tb/tb_ibuf_layer_ctrl.sv
// Directed bench for ibuf_layer_ctrl: inputs driven 1 time unit after posedge, outputs sampled there too.
module tb_ibuf_layer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_base_addr = '0;
  logic [31:0] cfg_ch_stride = '0;
  logic [15:0] cfg_num_ch = '0;
  logic        busy, done, init_addr_en, data_load, wgt_req, pe_start;
  logic [31:0] init_addr;
  logic        blkend = 1'b0;
  logic        mapend = 1'b0;
  logic        weight_load = 1'b0;
  logic        wgt_ready = 1'b0;
  logic        result_valid = 1'b0;
  logic [15:0] ch_cnt, blk_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pe = 0, n_ien = 0, n_dl = 0, n_done = 0, n_wreq = 0;

  ibuf_layer_ctrl #(.AW(32), .CW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_ch_stride(cfg_ch_stride), .cfg_num_ch(cfg_num_ch),
    .busy(busy), .done(done), .init_addr(init_addr), .init_addr_en(init_addr_en),
    .data_load(data_load), .blkend(blkend), .mapend(mapend), .weight_load(weight_load),
    .wgt_req(wgt_req), .wgt_ready(wgt_ready), .pe_start(pe_start),
    .result_valid(result_valid), .ch_cnt(ch_cnt), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pe_start)     n_pe++;
    if (init_addr_en) n_ien++;
    if (data_load)    n_dl++;
    if (done)         n_done++;
    if (wgt_req)      n_wreq++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // From a LOAD cycle: finish the block, no weight pending, return result; ends one cycle after result_valid.
  task automatic do_block(input logic last);
    tick;
    blkend = 1'b1; mapend = last;
    tick;
    blkend = 1'b0; mapend = 1'b0;
    chk("blk_dl_drop", data_load, 0);
    tick;
    chk("blk_pe_start", pe_start, 1);
    tick;
    result_valid = 1'b1;
    tick;
    result_valid = 1'b0;
  endtask

  task automatic go(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] nch);
    cfg_base_addr = base; cfg_ch_stride = stride; cfg_num_ch = nch;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  int pe0, ien0, dl0, done0, wr0;

  initial begin
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_init_en", init_addr_en, 0);
    chk("rst_dl", data_load, 0);
    tick;
    rst = 1'b0;
    tick;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_ch_cnt", ch_cnt, 0);
    chk("idle_blk_cnt", blk_cnt, 0);
    chk("idle_addr", init_addr, 0);

    // Two channels, three blocks each, no weights
    pe0 = n_pe; done0 = n_done;
    go(32'h1000, 32'h400, 16'd2);
    chk("t1_ien", init_addr_en, 1);
    chk("t1_addr0", init_addr, 32'h1000);
    chk("t1_busy", busy, 1);
    tick;
    for (int ch = 0; ch < 2; ch++) begin
      for (int b = 0; b < 3; b++) begin
        chk("t1_load_lvl", data_load, 1);
        tick;
        blkend = 1'b1; mapend = (b == 2);
        tick;
        blkend = 1'b0; mapend = 1'b0;
        chk("t1_dl_drop", data_load, 0);
        chk("t1_blk_cnt", blk_cnt, b + 1);
        tick;
        chk("t1_pe_start", pe_start, 1);
        tick;
        chk("t1_pe_1cyc", pe_start, 0);
        result_valid = 1'b1;
        tick;
        result_valid = 1'b0;
        if (b < 2) begin
          chk("t1_dl_next", data_load, 1);
        end else if (ch == 0) begin
          chk("t1_ien1", init_addr_en, 1);
          chk("t1_addr1", init_addr, 32'h1400);
          chk("t1_ch_cnt1", ch_cnt, 1);
          tick;
        end else begin
          chk("t1_done", done, 1);
          chk("t1_ch_cnt_fin", ch_cnt, 1);
          tick;
          chk("t1_done_1cyc", done, 0);
          chk("t1_busy_drop", busy, 0);
        end
      end
    end
    chk("t1_pe_total", n_pe - pe0, 6);
    chk("t1_done_total", n_done - done0, 1);

    // Zero channels
    pe0 = n_pe; ien0 = n_ien; dl0 = n_dl; done0 = n_done;
    go(32'h2000, 32'h100, 16'd0);
    chk("t2_busy", busy, 1);
    chk("t2_done", done, 1);
    tick;
    chk("t2_busy_drop", busy, 0);
    chk("t2_done_drop", done, 0);
    chk("t2_no_ien", n_ien - ien0, 0);
    chk("t2_no_dl", n_dl - dl0, 0);
    chk("t2_no_pe", n_pe - pe0, 0);
    chk("t2_done_cnt", n_done - done0, 1);

    // Weight fetch: pulse during LOAD, delivered in 5th WGT cycle
    wr0 = n_wreq;
    go(32'h3000, 32'h100, 16'd1);
    tick;
    weight_load = 1'b1;
    tick;
    weight_load = 1'b0;
    tick;
    blkend = 1'b1; mapend = 1'b1;
    tick;
    blkend = 1'b0; mapend = 1'b0;
    chk("t3_wreq_on", wgt_req, 1);
    for (int i = 0; i < 4; i++) tick;
    chk("t3_no_pe_yet", pe_start, 0);
    wgt_ready = 1'b1;
    tick;
    wgt_ready = 1'b0;
    chk("t3_pe_after_rdy", pe_start, 1);
    chk("t3_wreq_off", wgt_req, 0);
    chk("t3_wreq_cycles", n_wreq - wr0, 5);
    result_valid = 1'b1;
    tick;
    result_valid = 1'b0;
    chk("t3_done", done, 1);
    tick;

    // weight_load and wgt_ready together in WGT: stays pending
    go(32'h3000, 32'h100, 16'd1);
    tick;
    weight_load = 1'b1;
    tick;
    weight_load = 1'b0;
    blkend = 1'b1; mapend = 1'b1;
    tick;
    blkend = 1'b0; mapend = 1'b0;
    weight_load = 1'b1; wgt_ready = 1'b1;
    tick;
    weight_load = 1'b0; wgt_ready = 1'b0;
    chk("t4_wreq_hold", wgt_req, 1);
    chk("t4_no_pe", pe_start, 0);
    tick;
    chk("t4_wreq_hold2", wgt_req, 1);
    wgt_ready = 1'b1;
    tick;
    wgt_ready = 1'b0;
    chk("t4_pe_start", pe_start, 1);
    result_valid = 1'b1;
    tick;
    result_valid = 1'b0;
    chk("t4_done", done, 1);
    tick;

    // Abort in COMP of channel 1
    go(32'h1000, 32'h400, 16'd2);
    tick;
    do_block(1'b1);
    chk("t5_ien1", init_addr_en, 1);
    tick;
    tick;
    blkend = 1'b1; mapend = 1'b1;
    tick;
    blkend = 1'b0; mapend = 1'b0;
    tick;
    chk("t5_in_comp", pe_start, 1);
    chk("t5_ch_cnt", ch_cnt, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_pe", pe_start, 0);
    chk("t5_dl", data_load, 0);
    chk("t5_ch_cnt0", ch_cnt, 0);
    chk("t5_blk_cnt0", blk_cnt, 0);
    chk("t5_done0", done, 0);
    go(32'h1000, 32'h400, 16'd2);
    chk("t5_restart_addr", init_addr, 32'h1000);
    chk("t5_restart_ch", ch_cnt, 0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t5_abort_init", busy, 0);

    // Address wrap and start ignored while busy
    go(32'hFFFF_FC00, 32'h400, 16'd2);
    chk("t6_addr0", init_addr, 32'hFFFF_FC00);
    tick;
    cfg_base_addr = 32'h5000;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t6_still_load", data_load, 1);
    chk("t6_no_ien", init_addr_en, 0);
    blkend = 1'b1; mapend = 1'b1;
    tick;
    blkend = 1'b0; mapend = 1'b0;
    tick;
    chk("t6_pe", pe_start, 1);
    result_valid = 1'b1;
    tick;
    result_valid = 1'b0;
    chk("t6_ien1", init_addr_en, 1);
    chk("t6_wrap_addr", init_addr, 32'h0000_0000);
    chk("t6_ch_cnt1", ch_cnt, 1);
    tick;
    do_block(1'b1);
    chk("t6_done", done, 1);
    tick;
    chk("t6_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
